// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Memory-access stage between the execute unit (EXU) and the
//            writeback unit (WBU). Takes one bundle from the EXU, performs a
//            load or store over a single-outstanding AXI-lite subset (or
//            passes non-memory ops straight through), and hands the finished
//            bundle to the WBU as a one-cycle wbu_send_valid pulse.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            exu_valid / exu_ready         - EXU bundle handshake
//            mem_ren, mem_wen, mem_op,
//            mem_addr, mem_wdata           - memory request fields
//            alu_result, rd_i, reg_write_en_i, csr_*_i, csreg_write_en_i,
//            ecall_i, ebreak_i, pc_i, pc_next_i, instruction_i
//                                          - bundle fields carried to the WBU
//            wbu_send_valid + bundle outs  - registered bundle to the WBU
//            ar*/r*/aw*/w*/b*              - AXI-lite master channels
//            bus_err                       - sticky bus error flag
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // datapath formatting assumes 32
) (
  input  logic                clk,
  input  logic                rst,
  // EXU side
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [2:0]          mem_op,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [4:0]          rd_i,
  input  logic                reg_write_en_i,
  input  logic [1:0]          csr_rd_i,
  input  logic [DATA_W-1:0]   csr_wd_i,
  input  logic                csreg_write_en_i,
  input  logic                ecall_i,
  input  logic                ebreak_i,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         pc_next_i,
  input  logic [31:0]         instruction_i,
  // WBU side
  output logic                wbu_send_valid,
  output logic [4:0]          rd,
  output logic                reg_write_en,
  output logic [DATA_W-1:0]   wd,
  output logic [1:0]          csr_rd,
  output logic [DATA_W-1:0]   csr_wd,
  output logic                csreg_write_en,
  output logic                ecall,
  output logic                ebreak,
  output logic [31:0]         pc,
  output logic [31:0]         pc_next,
  output logic [31:0]         instruction,
  // AXI-lite read
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  // AXI-lite write
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RREQ  = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_SEND  = 3'd5
  } state_e;

  state_e              state_q;
  logic                exu_ready_q, send_q, bus_err_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [2:0]          op_q;
  logic [1:0]          off_q;

  logic [4:0]          rd_q;
  logic                reg_write_en_q;
  logic [DATA_W-1:0]   wd_q;
  logic [1:0]          csr_rd_q;
  logic [DATA_W-1:0]   csr_wd_q;
  logic                csreg_write_en_q, ecall_q, ebreak_q;
  logic [31:0]         pc_q, pc_next_q, instruction_q;

  // Store lane placement, computed from the EXU inputs at accept time.
  // The data shift follows the same lane the strobe selects, so a halfword
  // ignores addr[0] and a word ignores addr[1:0] consistently.
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W/8-1:0] wstrb_d;

  always_comb begin
    wdata_d = mem_wdata;
    wstrb_d = 4'b1111;
    case (mem_op[1:0])
      2'b00: begin
        wdata_d = mem_wdata << {mem_addr[1:0], 3'b000};
        wstrb_d = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        wdata_d = mem_wdata << {mem_addr[1], 4'b0000};
        wstrb_d = 4'b0011 << {mem_addr[1], 1'b0};
      end
      default: begin
        wdata_d = mem_wdata;
        wstrb_d = 4'b1111;
      end
    endcase
  end

  // Load data alignment and extension using the latched funct3/offset.
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [DATA_W-1:0] wd_load_d;

  always_comb begin
    rbyte = rdata[7:0];
    case (off_q)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (op_q)
      3'b000:  wd_load_d = {{24{rbyte[7]}}, rbyte};
      3'b001:  wd_load_d = {{16{rhalf[15]}}, rhalf};
      3'b100:  wd_load_d = {24'd0, rbyte};
      3'b101:  wd_load_d = {16'd0, rhalf};
      default: wd_load_d = rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      exu_ready_q      <= 1'b1;
      send_q           <= 1'b0;
      bus_err_q        <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      bready_q         <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      op_q             <= '0;
      off_q            <= '0;
      rd_q             <= '0;
      reg_write_en_q   <= 1'b0;
      wd_q             <= '0;
      csr_rd_q         <= '0;
      csr_wd_q         <= '0;
      csreg_write_en_q <= 1'b0;
      ecall_q          <= 1'b0;
      ebreak_q         <= 1'b0;
      pc_q             <= '0;
      pc_next_q        <= '0;
      instruction_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exu_valid) begin
            exu_ready_q      <= 1'b0;
            rd_q             <= rd_i;
            reg_write_en_q   <= reg_write_en_i;
            wd_q             <= alu_result;
            csr_rd_q         <= csr_rd_i;
            csr_wd_q         <= csr_wd_i;
            csreg_write_en_q <= csreg_write_en_i;
            ecall_q          <= ecall_i;
            ebreak_q         <= ebreak_i;
            pc_q             <= pc_i;
            pc_next_q        <= pc_next_i;
            instruction_q    <= instruction_i;
            op_q             <= mem_op;
            off_q            <= mem_addr[1:0];
            addr_q           <= mem_addr;
            wdata_q          <= wdata_d;
            wstrb_q          <= wstrb_d;
            if (mem_ren) begin
              arvalid_q <= 1'b1;
              state_q   <= S_RREQ;
            end else if (mem_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WREQ;
            end else begin
              send_q  <= 1'b1;
              state_q <= S_SEND;
            end
          end
        end
        S_RREQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            wd_q     <= wd_load_d;
            send_q   <= 1'b1;
            state_q  <= S_SEND;
            if (rresp != 2'b00) bus_err_q <= 1'b1;
          end
        end
        S_WREQ: begin
          // AW and W complete independently; leave once neither is pending.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            send_q   <= 1'b1;
            state_q  <= S_SEND;
            if (bresp != 2'b00) bus_err_q <= 1'b1;
          end
        end
        S_SEND: begin
          send_q      <= 1'b0;
          exu_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          send_q      <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          exu_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign exu_ready      = exu_ready_q;
  assign wbu_send_valid = send_q;
  assign bus_err        = bus_err_q;
  assign rd             = rd_q;
  assign reg_write_en   = reg_write_en_q;
  assign wd             = wd_q;
  assign csr_rd         = csr_rd_q;
  assign csr_wd         = csr_wd_q;
  assign csreg_write_en = csreg_write_en_q;
  assign ecall          = ecall_q;
  assign ebreak         = ebreak_q;
  assign pc             = pc_q;
  assign pc_next        = pc_next_q;
  assign instruction    = instruction_q;
  assign araddr         = addr_q;
  assign arvalid        = arvalid_q;
  assign rready         = rready_q;
  assign awaddr         = addr_q;
  assign awvalid        = awvalid_q;
  assign wdata          = wdata_q;
  assign wstrb          = wstrb_q;
  assign wvalid         = wvalid_q;
  assign bready         = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu. The bench plays the EXU
//            and a cycle-exact AXI-lite slave; all expected values are
//            hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid = 1'b0, exu_ready;
  logic        mem_ren = 1'b0, mem_wen = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, alu_result = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        reg_write_en_i = 1'b0;
  logic [1:0]  csr_rd_i = 2'd2;
  logic [31:0] csr_wd_i = 32'h0000CAFE;
  logic        csreg_write_en_i = 1'b1, ecall_i = 1'b0, ebreak_i = 1'b1;
  logic [31:0] pc_i = 32'h80000000, pc_next_i = 32'h80000004;
  logic [31:0] instruction_i = 32'h00000013;
  logic        wbu_send_valid;
  logic [4:0]  rd;
  logic        reg_write_en;
  logic [31:0] wd;
  logic [1:0]  csr_rd;
  logic [31:0] csr_wd;
  logic        csreg_write_en, ecall, ebreak;
  logic [31:0] pc, pc_next, instruction;
  logic [31:0] araddr;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rvalid = 1'b0, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'd0;
  logic        bvalid = 1'b0, bready;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_result(alu_result),
    .rd_i(rd_i), .reg_write_en_i(reg_write_en_i),
    .csr_rd_i(csr_rd_i), .csr_wd_i(csr_wd_i), .csreg_write_en_i(csreg_write_en_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .pc_i(pc_i), .pc_next_i(pc_next_i), .instruction_i(instruction_i),
    .wbu_send_valid(wbu_send_valid), .rd(rd), .reg_write_en(reg_write_en), .wd(wd),
    .csr_rd(csr_rd), .csr_wd(csr_wd), .csreg_write_en(csreg_write_en),
    .ecall(ecall), .ebreak(ebreak), .pc(pc), .pc_next(pc_next), .instruction(instruction),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle for a single cycle (IDLE is assumed, so it is accepted).
  task automatic issue(input logic ren, input logic wen, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [31:0] alu, input logic [4:0] rdn, input logic rwe);
    exu_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_op = op;
    mem_addr = addr; mem_wdata = wdat; alu_result = alu;
    rd_i = rdn; reg_write_en_i = rwe;
    tick();
    exu_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic do_alu(input string tag, input logic [31:0] alu, input logic [4:0] rdn);
    issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, alu, rdn, 1'b1);
    check({tag, " send"}, wbu_send_valid, 1);
    check({tag, " wd"}, wd, alu);
    check({tag, " rd"}, rd, rdn);
    check({tag, " ready_low"}, exu_ready, 0);
    tick();
    check({tag, " send_drop"}, wbu_send_valid, 0);
    check({tag, " ready_back"}, exu_ready, 1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rd_val, input logic [31:0] exp, input int ar_delay);
    issue(1'b1, 1'b0, op, addr, 32'd0, 32'h0BAD0BAD, 5'd3, 1'b1);
    check({tag, " arvalid"}, arvalid, 1);
    check({tag, " araddr"}, araddr, addr);
    check({tag, " ready_low"}, exu_ready, 0);
    for (int i = 0; i < ar_delay; i++) begin
      tick();
      check({tag, " bp_arvalid"}, arvalid, 1);
      check({tag, " bp_araddr"}, araddr, addr);
      check({tag, " bp_send"}, wbu_send_valid, 0);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check({tag, " ar_drop"}, arvalid, 0);
    check({tag, " rready"}, rready, 1);
    tick();
    check({tag, " rwait_rready"}, rready, 1);
    check({tag, " rwait_send"}, wbu_send_valid, 0);
    rvalid = 1'b1; rdata = rd_val; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    check({tag, " send"}, wbu_send_valid, 1);
    check({tag, " wd"}, wd, exp);
    check({tag, " rready_drop"}, rready, 0);
    tick();
    check({tag, " send_drop"}, wbu_send_valid, 0);
    check({tag, " ready_back"}, exu_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input int aw_d, input int w_d,
                          input logic [1:0] bresp_v);
    int last;
    last = (aw_d > w_d) ? aw_d : w_d;
    issue(1'b0, 1'b1, op, addr, data, 32'd0, 5'd0, 1'b0);
    check({tag, " awaddr"}, awaddr, addr);
    check({tag, " wdata"}, wdata, exp_wdata);
    check({tag, " wstrb"}, {28'd0, wstrb}, {28'd0, exp_strb});
    for (int c = 0; c <= last; c++) begin
      check({tag, " awvalid"}, awvalid, (c <= aw_d) ? 1 : 0);
      check({tag, " wvalid"}, wvalid, (c <= w_d) ? 1 : 0);
      check({tag, " wdata_stable"}, wdata, exp_wdata);
      check({tag, " bready_early"}, bready, 0);
      awready = (c == aw_d);
      wready  = (c == w_d);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    check({tag, " aw_done"}, awvalid, 0);
    check({tag, " w_done"}, wvalid, 0);
    check({tag, " bready"}, bready, 1);
    tick();
    check({tag, " bwait_bready"}, bready, 1);
    check({tag, " bwait_send"}, wbu_send_valid, 0);
    bvalid = 1'b1; bresp = bresp_v;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check({tag, " send"}, wbu_send_valid, 1);
    check({tag, " bready_drop"}, bready, 0);
    check({tag, " rwe"}, reg_write_en, 0);
    tick();
    check({tag, " send_drop"}, wbu_send_valid, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst exu_ready", exu_ready, 1);
    check("rst send", wbu_send_valid, 0);
    check("rst arvalid", arvalid, 0);
    check("rst awvalid", awvalid, 0);
    check("rst wvalid", wvalid, 0);
    check("rst rready", rready, 0);
    check("rst bready", bready, 0);
    check("rst bus_err", bus_err, 0);
    check("rst wd", wd, 32'd0);
    check("rst rd", rd, 32'd0);
    check("rst pc", pc, 32'd0);
    rst = 1'b0;
    tick();

    // Non-memory op: one-cycle latency, bundle fields carried through
    do_alu("alu1", 32'h00001234, 5'd5);
    check("alu1 pc", pc, 32'h80000000);
    check("alu1 pc_next", pc_next, 32'h80000004);
    check("alu1 instr", instruction, 32'h00000013);
    check("alu1 csr_wd", csr_wd, 32'h0000CAFE);
    check("alu1 csr_rd", csr_rd, 32'd2);
    check("alu1 ebreak", ebreak, 1);
    check("alu1 wd_hold", wd, 32'h00001234);

    // Loads (first one with 5 cycles of arready backpressure)
    do_load("lb",  3'b000, 32'h80000003, 32'h80FF1122, 32'hFFFFFF80, 5);
    do_load("lbu", 3'b100, 32'h80000003, 32'h80FF1122, 32'h00000080, 0);
    do_load("lh",  3'b001, 32'h80000002, 32'h80FF1122, 32'hFFFF80FF, 1);
    do_load("lhu", 3'b101, 32'h80000000, 32'h80FF1122, 32'h00001122, 0);
    do_load("lw",  3'b010, 32'h80000000, 32'h80FF1122, 32'h80FF1122, 2);

    // Stores: AW before W, W before AW, both together with an error response
    do_store("sh", 3'b001, 32'h00000102, 32'h0000ABCD, 4'b1100, 32'hABCD0000, 0, 2, 2'b00);
    do_store("sb", 3'b000, 32'h00000101, 32'h000000AB, 4'b0010, 32'h0000AB00, 1, 0, 2'b00);
    check("pre_err bus_err", bus_err, 0);
    do_store("sw", 3'b010, 32'h00000200, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1, 1, 2'b10);
    check("sw bus_err", bus_err, 1);

    // bus_err is sticky across later instructions
    do_alu("alu2", 32'h00000042, 5'd9);
    check("alu2 bus_err", bus_err, 1);
    do_load("lw2", 3'b010, 32'h00000010, 32'h13572468, 32'h13572468, 0);
    check("lw2 bus_err", bus_err, 1);

    // Reset while waiting in RDATA
    issue(1'b1, 1'b0, 3'b010, 32'h00000020, 32'd0, 32'd0, 5'd4, 1'b1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("abort pre rready", rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort exu_ready", exu_ready, 1);
    check("abort rready", rready, 0);
    check("abort arvalid", arvalid, 0);
    check("abort send", wbu_send_valid, 0);
    check("abort bus_err", bus_err, 0);
    tick();
    check("abort send2", wbu_send_valid, 0);
    do_alu("alu3", 32'h000055AA, 5'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
